// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch slice.
// Entry layout, queue depth, run/halt state and the NOP filler.
package fetch_pkg;

  localparam int unsigned FQ_DEPTH = 2;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  typedef enum logic {
    RUN,
    HALTED
  } fstate_t;

  function automatic logic [31:0] word_align(
    input logic [31:0] a
  );
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_if.sv
// Fetch-side buses: icache read port and the valid/ready port to decode.
// master = fetch_ctrl, slave = icache + decode environment.
interface fetch_if;

  logic        ic_en;
  logic [31:0] ic_addr;
  logic [31:0] ic_rdata;
  logic        ic_rvalid;

  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        out_ready;

  modport master (
    output ic_en,
    output ic_addr,
    input  ic_rdata,
    input  ic_rvalid,
    output out_valid,
    output out_pc,
    output out_instr,
    input  out_ready
  );

  modport slave (
    input  ic_en,
    input  ic_addr,
    output ic_rdata,
    output ic_rvalid,
    input  out_valid,
    input  out_pc,
    input  out_instr,
    output out_ready
  );

endinterface

// File: rtl/fetch_queue.sv
// Two-entry {pc, instr} FIFO toward decode; head registered, no bypass.
// Flush wins over push and pop.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP      = NOP_INSTR
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  fetch_entry_t din_i,
  output fetch_entry_t head_o,
  output logic         valid_o,
  output logic [1:0]   count_o
);

  fetch_entry_t e0_q, e0_d;
  fetch_entry_t e1_q, e1_d;
  logic [1:0]   cnt_q, cnt_d;
  logic         do_push, do_pop;

  assign do_push = push_i && (cnt_q != 2'(FQ_DEPTH) || pop_i);
  assign do_pop  = pop_i && (cnt_q != 2'd0);

  always_comb begin
    e0_d  = e0_q;
    e1_d  = e1_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      cnt_d = 2'd0;
    end else begin
      unique case ({do_push, do_pop})
        2'b10: begin
          if (cnt_q == 2'd0) e0_d = din_i;
          else               e1_d = din_i;
          cnt_d = cnt_q + 2'd1;
        end
        2'b01: begin
          e0_d  = e1_q;
          cnt_d = cnt_q - 2'd1;
        end
        2'b11: begin
          // Head leaves while the new entry lands behind the survivor.
          if (cnt_q == 2'd1) begin
            e0_d = din_i;
          end else begin
            e0_d = e1_q;
            e1_d = din_i;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      e0_q  <= '{pc: RESET_PC, instr: NOP};
      e1_q  <= '{pc: RESET_PC, instr: NOP};
      cnt_q <= 2'd0;
    end else begin
      e0_q  <= e0_d;
      e1_q  <= e1_d;
      cnt_q <= cnt_d;
    end
  end

  assign valid_o      = (cnt_q != 2'd0);
  assign count_o      = cnt_q;
  assign head_o.pc    = e0_q.pc;
  assign head_o.instr = valid_o ? e0_q.instr : NOP;

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: PC generation, single in-flight icache read,
// redirect squash, halt gating and the decode-side queue.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP      = NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        halt,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  fetch_if.master     bus,
  output logic        err_spurious
);

  logic [31:0]  fetch_pc_q, fetch_pc_d;
  logic         inflight_q, inflight_d;
  logic [31:0]  inflight_pc_q, inflight_pc_d;
  logic         err_q, err_d;

  fstate_t      state;
  logic [31:0]  pc_r;
  logic [1:0]   count;
  logic [2:0]   occ;
  logic         pop, push, issue;
  fetch_entry_t head;
  fetch_entry_t din;

  // halt acts in the same cycle, so the run/halt state is decoded, not stored.
  assign state = halt ? HALTED : RUN;
  assign pc_r  = word_align(redirect_pc);
  assign pop   = bus.out_valid & bus.out_ready;
  assign occ   = {1'b0, count} + {2'b0, inflight_q} - {2'b0, pop};

  assign issue = rst_n && (state == RUN)
              && (redirect_valid || occ < 3'(FQ_DEPTH));

  assign bus.ic_en   = issue;
  assign bus.ic_addr = redirect_valid ? pc_r : fetch_pc_q;

  assign push      = bus.ic_rvalid & inflight_q & ~redirect_valid;
  assign din.pc    = inflight_pc_q;
  assign din.instr = bus.ic_rdata;

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    inflight_d    = inflight_q;
    inflight_pc_d = inflight_pc_q;
    err_d         = err_q | (bus.ic_rvalid & ~inflight_q);
    if (issue) begin
      fetch_pc_d    = bus.ic_addr + 32'd4;
      inflight_d    = 1'b1;
      inflight_pc_d = bus.ic_addr;
    end else if (redirect_valid) begin
      fetch_pc_d = pc_r;
      inflight_d = 1'b0;
    end else if (bus.ic_rvalid) begin
      inflight_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_pc_q    <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= RESET_PC;
      err_q         <= 1'b0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      err_q         <= err_d;
    end
  end

  fetch_queue #(
    .RESET_PC (RESET_PC),
    .NOP      (NOP)
  ) u_fq (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (redirect_valid),
    .push_i  (push),
    .pop_i   (pop & ~redirect_valid),
    .din_i   (din),
    .head_o  (head),
    .valid_o (bus.out_valid),
    .count_o (count)
  );

  assign bus.out_pc    = head.pc;
  assign bus.out_instr = head.instr;
  assign err_spurious  = err_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with a 1-cycle icache model
// (word i holds 32'h1000_0000 + i).
module tb_fetch_ctrl;
  import fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        halt;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        err_spurious;
  logic        rv_m = 1'b0;
  logic [31:0] rd_m = 32'h0;
  logic        spur;
  int          n_assert = 0;
  int          n_fail = 0;

  localparam logic [31:0] IB = 32'h1000_0000;

  always #5 clk = ~clk;

  fetch_if bus ();

  fetch_ctrl #(
    .RESET_PC (32'h0000_0000),
    .NOP      (32'h0000_0013)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .halt           (halt),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .bus            (bus),
    .err_spurious   (err_spurious)
  );

  always @(posedge clk) begin
    rv_m <= bus.ic_en;
    rd_m <= IB + (bus.ic_addr >> 2);
  end

  assign bus.ic_rvalid = rv_m | spur;
  assign bus.ic_rdata  = rd_m;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    halt = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    spur = 1'b0;
    bus.out_ready = 1'b1;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_pc", bus.out_pc, 0);
    chk("rst_instr", bus.out_instr, 32'h13);
    chk("rst_en", bus.ic_en, 0);
    chk("rst_err", err_spurious, 0);

    // release and stream
    rst_n = 1'b1;
    #1;
    chk("rel_en", bus.ic_en, 1);
    chk("rel_addr", bus.ic_addr, 0);
    @(negedge clk);
    chk("c1_valid", bus.out_valid, 0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("str_valid", bus.out_valid, 1);
      chk("str_pc", bus.out_pc, 32'(4 * i));
      chk("str_instr", bus.out_instr, IB + 32'(i));
    end

    // mid-stream reset, then stall with out_ready=0
    rst_n = 1'b0;
    bus.out_ready = 1'b0;
    @(negedge clk);
    chk("mrst_valid", bus.out_valid, 0);
    chk("mrst_en", bus.ic_en, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("stall3_en", bus.ic_en, 0);
    chk("stall3_pc", bus.out_pc, 0);
    repeat (7) @(negedge clk);
    chk("stall10_en", bus.ic_en, 0);
    chk("stall10_valid", bus.out_valid, 1);
    chk("stall10_pc", bus.out_pc, 0);
    chk("stall10_instr", bus.out_instr, IB);
    bus.out_ready = 1'b1;
    for (int i = 1; i < 4; i++) begin
      @(negedge clk);
      chk("resume_pc", bus.out_pc, 32'(4 * i));
      chk("resume_instr", bus.out_instr, IB + 32'(i));
    end

    // redirect with pop and response in the same cycle
    @(negedge clk);
    chk("pre_redir_pc", bus.out_pc, 32'h10);
    redirect_valid = 1'b1;
    redirect_pc = 32'h40;
    #1;
    chk("redir_en", bus.ic_en, 1);
    chk("redir_addr", bus.ic_addr, 32'h40);
    @(negedge clk);
    chk("redir_flush", bus.out_valid, 0);
    redirect_valid = 1'b0;
    @(negedge clk);
    chk("redir_valid", bus.out_valid, 1);
    chk("redir_pc0", bus.out_pc, 32'h40);
    chk("redir_instr0", bus.out_instr, IB + 32'h10);
    @(negedge clk);
    chk("redir_pc1", bus.out_pc, 32'h44);

    // unaligned redirect target
    redirect_valid = 1'b1;
    redirect_pc = 32'h43;
    #1;
    chk("unal_addr", bus.ic_addr, 32'h40);
    @(negedge clk);
    chk("unal_flush", bus.out_valid, 0);
    redirect_valid = 1'b0;
    @(negedge clk);
    chk("unal_pc0", bus.out_pc, 32'h40);
    @(negedge clk);
    chk("unal_pc1", bus.out_pc, 32'h44);
    chk("unal_instr1", bus.out_instr, IB + 32'h11);

    // halt: same-cycle gating, drain of in-flight entry
    halt = 1'b1;
    #1;
    chk("halt_en", bus.ic_en, 0);
    @(negedge clk);
    chk("halt_last_valid", bus.out_valid, 1);
    chk("halt_last_pc", bus.out_pc, 32'h48);
    @(negedge clk);
    chk("halt_empty", bus.out_valid, 0);
    chk("halt_nop", bus.out_instr, 32'h13);
    chk("halt_en2", bus.ic_en, 0);
    redirect_valid = 1'b1;
    redirect_pc = 32'h80;
    #1;
    chk("hredir_en", bus.ic_en, 0);
    @(negedge clk);
    redirect_valid = 1'b0;
    halt = 1'b0;
    #1;
    chk("unhalt_en", bus.ic_en, 1);
    chk("unhalt_addr", bus.ic_addr, 32'h80);
    @(negedge clk);
    chk("unhalt_c1", bus.out_valid, 0);
    @(negedge clk);
    chk("unhalt_pc", bus.out_pc, 32'h80);
    chk("unhalt_instr", bus.out_instr, IB + 32'h20);

    // halt again, then a spurious response
    halt = 1'b1;
    @(negedge clk);
    chk("h2_pc", bus.out_pc, 32'h84);
    @(negedge clk);
    chk("h2_empty", bus.out_valid, 0);
    chk("pre_spur_err", err_spurious, 0);
    spur = 1'b1;
    @(negedge clk);
    spur = 1'b0;
    chk("spur_err", err_spurious, 1);
    chk("spur_nopush", bus.out_valid, 0);
    repeat (3) @(negedge clk);
    chk("spur_sticky", err_spurious, 1);
    chk("spur_nopush2", bus.out_valid, 0);

    // resume, then reset mid-stream
    halt = 1'b0;
    repeat (3) @(negedge clk);
    chk("res2_valid", bus.out_valid, 1);
    chk("res2_pc", bus.out_pc, 32'h8C);
    rst_n = 1'b0;
    #1;
    chk("rst2_en", bus.ic_en, 0);
    @(negedge clk);
    chk("rst2_valid", bus.out_valid, 0);
    chk("rst2_err", err_spurious, 0);
    chk("rst2_pc", bus.out_pc, 0);
    chk("rst2_instr", bus.out_instr, 32'h13);
    rst_n = 1'b1;
    #1;
    chk("rst2_addr", bus.ic_addr, 0);
    @(negedge clk);
    chk("rst2_c1", bus.out_valid, 0);
    @(negedge clk);
    chk("rst2_pc0", bus.out_pc, 0);
    chk("rst2_instr0", bus.out_instr, IB);
    chk("rst2_err2", err_spurious, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Instruction-fetch sequencer between the PC/redirect logic and the synchronous instruction cache (1-cycle BRAM-style read, `rvalid` one cycle after `en`). It generates sequential fetch addresses, tracks the single in-flight cache read, and buffers returned {pc, instr} pairs in a 2-entry queue toward decode with valid/ready backpressure. It squashes wrong-path reads on redirect and supports halting.

## Interface
- `RESET_PC`, 32'h0000_0000, first fetch address after reset
- `NOP`, 32'h0000_0013, instruction value presented on `out_instr` when the queue is empty
- `clk`  in  1  clock
- `rst_n`  in  1  synchronous active-low reset
- `halt`  in  1  level; while 1, no new cache reads are issued
- `redirect_valid`  in  1  one-cycle pulse: flush and restart at `redirect_pc`
- `redirect_pc`  in  32  new fetch address; bits [1:0] are ignored and treated as 0
- `ic_en`  out  1  cache read enable
- `ic_addr`  out  32  cache read byte address, word aligned
- `ic_rdata`  in  32  cache read data
- `ic_rvalid`  in  1  cache data valid, one cycle after `ic_en`
- `out_valid`  out  1  queue head valid
- `out_pc`  out  32  PC of the head entry
- `out_instr`  out  32  instruction of the head entry
- `out_ready`  in  1  decode accepts the head entry
- `err_spurious`  out  1  sticky flag: `ic_rvalid` arrived with no read in flight

## Operation
- State FSM in `fetch_pkg::fstate_t`, with two states: RUN and HALTED.
  - RUN→HALTED when `halt`=1.
  - HALTED→RUN when `halt`=0.
  - The transition takes effect in the same cycle: `halt` gates `ic_en` combinationally.
- Registers:
  - `fetch_pc`: next address to issue.
  - `inflight`, `inflight_pc`: the outstanding read and its address.
  - 2-entry queue with a count of 0–2.
  - `err_spurious`.
- `occ = count + inflight - (out_valid & out_ready)`. Issue when state is RUN, `halt`=0, and `occ < 2`. This guarantees the queue has space for every response, with no drop and no overflow.
- On issue without redirect:
  - `ic_addr = fetch_pc`.
  - `fetch_pc += 4`, modulo 2^32, so 32'hFFFF_FFFC wraps to 0.
  - `inflight ← 1` and `inflight_pc ← fetch_pc`.
- Response: when `ic_rvalid & inflight` and no redirect this cycle, push {`inflight_pc`, `ic_rdata`}. When no new issue occurs, `inflight ← 0`.
- Redirect cycle, with priority over everything else:
  - Flush the queue (count ← 0).
  - Discard any response visible this cycle.
  - Ignore any pop this cycle.
  - `pc_r = {redirect_pc[31:2], 2'b00}`.
  - If not halted, issue `pc_r` this cycle: `ic_addr = pc_r`, `fetch_pc ← pc_r + 4`, `inflight ← 1`.
  - If halted, `fetch_pc ← pc_r` and `inflight ← 0`.
- Simultaneous push and pop are allowed: count stays the same and order is preserved.
- `ic_rvalid` while `inflight`=0 is not pushed and sets `err_spurious`. The flag is cleared only by reset.

## Timing
- Reset, while `rst_n`=0 at a posedge, gives:
  - `fetch_pc`=`RESET_PC`, `inflight`=0, count=0, `err_spurious`=0, state RUN.
  - `ic_en` is forced to 0 combinationally whenever `rst_n`=0.
  - `out_valid`=0, `out_pc`=`RESET_PC`, `out_instr`=`NOP`.
- Reset mid-operation discards the queue and the in-flight read; the cache response one cycle later is ignored.
- Fetch-to-out latency: issue in cycle t, data visible in t+1, pushed at the end of t+1, `out_valid` in t+2. The queue output is registered; there is no bypass.
- Steady state with `out_ready`=1 gives 1 instruction per cycle.
- With `out_ready`=0, `ic_en` drops once `count + inflight` = 2. Head outputs hold stable while `out_valid & !out_ready`.
- After redirect in cycle t, the first new `out_valid` is in t+2 with `out_pc` = `pc_r`.
- After `halt` rises, at most one more entry (the in-flight read) is pushed. The queue keeps draining.

## Structure
- `fetch_pkg`:
  - `fetch_entry_t` struct {`pc`[31:0], `instr`[31:0]}.
  - `fstate_t` enum {RUN, HALTED}.
  - `NOP_INSTR` constant.
  - `FQ_DEPTH`=2.
- Sub-module `fetch_queue`: 2-entry FIFO of `fetch_entry_t` with push, pop and flush inputs, and count, head and valid outputs. Flush has priority over push and pop.
- `fetch_ctrl` holds the FSM, the PC/in-flight tracking and the issue logic.

## Test plan
- Reset release with an icache model (word i = 32'h1000_0000+i) and `out_ready`=1 → `out_valid` in cycle 2; `out_pc` sequence 0,4,8,… one per cycle; `out_instr` = 32'h1000_0000, 32'h1000_0001, …
- `out_ready`=0 for 10 cycles → `ic_en`=0 after 2 entries; head holds `pc`=0. Then `out_ready`=1 → `pc` 0,4,8,… with no gap, loss or duplicate.
- Redirect to 32'h40 while streaming at `pc`=0x10 → stale response dropped; next `out_pc` = 0x40 two cycles later, then 0x44. Redirect to 32'h43 → `out_pc` 0x40.
- Redirect asserted in the same cycle as a pop and a response → count 0 next cycle; no old-path PC ever appears at the output.
- `halt`=1 → `ic_en`=0 in the same cycle; the queue drains; `out_valid` falls. A redirect to 0x80 while halted, then `halt`=0 → first `out_pc` = 0x80.
- Force `ic_rvalid`=1 with no read in flight → no push; `err_spurious`=1 until reset. A mid-stream `rst_n`=0 → `out_valid`=0 and `fetch_pc` restarts at `RESET_PC`.
